// File: rtl/sync_fifo_pkg.sv
// Shared types for the synchronous FIFO: per-cycle operation decode.
package sync_fifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  // Qualified push/pop strobes folded into a single operation code.
  function automatic fifo_op_e decode_op(input logic push, input logic pop);
    return fifo_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port storage: synchronous write, asynchronous read (distributed RAM style).
module sync_fifo_ram #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LOG2_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [LOG2_DEPTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic [LOG2_DEPTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;

  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo.sv
// First-word-fall-through single-clock FIFO with occupancy flags for upstream flow control.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned LOG2_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write,
  input  logic             read,
  input  logic [WIDTH-1:0] dataIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             dataPresent,
  output logic             halfFull,
  output logic             full
);

  localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
  localparam int unsigned PW    = LOG2_DEPTH;
  localparam int unsigned CW    = LOG2_DEPTH + 1;

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          wr_ok;
  logic          rd_ok;
  fifo_op_e      op;

  // Guards use pre-edge flags, so a write while full is dropped even if a read pops.
  always_comb begin
    wr_ok      = write && !full;
    rd_ok      = read && dataPresent;
    op         = decode_op(wr_ok, rd_ok);
    count_next = count;
    case (op)
      OP_PUSH: count_next = count + CW'(1);
      OP_POP:  count_next = count - CW'(1);
      default: ;
    endcase
  end

  // Flags are registered from the next count so they track count exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      dataPresent <= 1'b0;
      halfFull    <= 1'b0;
      full        <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok) rd_ptr <= rd_ptr + PW'(1);
      count       <= count_next;
      dataPresent <= (count_next != '0);
      halfFull    <= (count_next >= CW'(DEPTH / 2));
      full        <= (count_next == CW'(DEPTH));
    end
  end

  sync_fifo_ram #(
    .WIDTH      (WIDTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_ok),
    .waddr (wr_ptr),
    .wdata (dataIn),
    .raddr (rd_ptr),
    .rdata (dataOut)
  );

endmodule

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo: queue scoreboard plus directed boundary cases.
module tb_sync_fifo;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned LOG2_DEPTH = 4;
  localparam int unsigned DEPTH      = 1 << LOG2_DEPTH;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             write = 1'b0;
  logic             read = 1'b0;
  logic [WIDTH-1:0] dataIn = '0;
  logic [WIDTH-1:0] dataOut;
  logic             dataPresent;
  logic             halfFull;
  logic             full;

  logic [WIDTH-1:0] model [$];
  int errors = 0;
  int checks = 0;

  sync_fifo #(
    .WIDTH      (WIDTH),
    .LOG2_DEPTH (LOG2_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .write       (write),
    .read        (read),
    .dataIn      (dataIn),
    .dataOut     (dataOut),
    .dataPresent (dataPresent),
    .halfFull    (halfFull),
    .full        (full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_present"}, 32'(dataPresent), 32'(model.size() != 0));
    check({tag, "_half"},    32'(halfFull),    32'(model.size() >= DEPTH / 2));
    check({tag, "_full"},    32'(full),        32'(model.size() == DEPTH));
    if (model.size() != 0) check({tag, "_head"}, 32'(dataOut), 32'(model[0]));
  endtask

  // One clock of stimulus; expected words are popped from the scoreboard as the DUT pops them.
  task automatic step(input logic w, input logic r, input logic [WIDTH-1:0] d);
    logic wr_ok, rd_ok;
    write  = w;
    read   = r;
    dataIn = d;
    wr_ok  = w && (model.size() < DEPTH);
    rd_ok  = r && (model.size() != 0);
    if (rd_ok) check("pop_data", 32'(dataOut), 32'(model.pop_front()));
    if (wr_ok) model.push_back(d);
    @(posedge clk);
    #1;
    write = 1'b0;
    read  = 1'b0;
    check_flags("step");
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model.delete();
    check("rst_present", 32'(dataPresent), 32'(0));
    check("rst_half",    32'(halfFull),    32'(0));
    check("rst_full",    32'(full),        32'(0));
  endtask

  initial begin
    // Reset then idle, and a read while empty.
    do_reset();
    step(1'b0, 1'b0, '0);
    step(1'b0, 1'b1, '0);

    // Single word fall-through and pop.
    step(1'b1, 1'b0, 8'h11);
    check("fwft_11", 32'(dataOut), 32'h11);
    check("fwft_present", 32'(dataPresent), 32'(1));
    step(1'b0, 1'b1, '0);
    check("pop_empty", 32'(dataPresent), 32'(0));

    // Fill to full, drop 17th write, drain in order.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i));
      if (i == 7)  check("half_at_8", 32'(halfFull), 32'(1));
      if (i == 14) check("notfull_15", 32'(full), 32'(0));
    end
    check("full_at_16", 32'(full), 32'(1));
    step(1'b1, 1'b0, 8'hFF);
    check("drop_head", 32'(dataOut), 32'h00);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, '0);
    check("drained", 32'(dataPresent), 32'(0));

    // Wrap-around with 3 resident words.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(8'h40 + i));
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 8'(8'h80 + i));
      check("wrap_count", 32'(model.size()), 32'(3));
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, '0);

    // Simultaneous write+read when empty.
    step(1'b1, 1'b1, 8'h5C);
    check("both_empty_head", 32'(dataOut), 32'h5C);
    check("both_empty_half", 32'(halfFull), 32'(0));
    step(1'b0, 1'b1, '0);

    // Simultaneous write+read when full: write dropped.
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'hC0 + i));
    step(1'b1, 1'b1, 8'hEE);
    check("both_full_full", 32'(full), 32'(0));
    check("both_full_head", 32'(dataOut), 32'hC1);
    check("both_full_size", 32'(model.size()), 32'(15));
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, '0);
    check("both_full_drain", 32'(dataPresent), 32'(0));

    // Reset mid-operation with 5 words held.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h30 + i));
    write = 1'b1;
    read  = 1'b1;
    dataIn = 8'h77;
    do_reset();
    write = 1'b0;
    read  = 1'b0;
    step(1'b1, 1'b0, 8'hA5);
    check("post_rst_a5", 32'(dataOut), 32'hA5);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
